ram_arbiter: RTL

Round-robin arbiter that shares one port of the team's synchronous RAM (registered read, 1-cycle latency, zero output when read enable low) among NUM_REQ requesters. Each requester issues a read or write with a req/ack handshake. The arbiter grants one requester at a time, drives the RAM port, captures read data and returns a one-cycle ack. It sits between CPU/DMA/peripheral masters and a ram instance.

---
 rtl/ram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among NUM_REQ requesters.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK and returns a one-cycle ack.
module ram_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8
) (
  input  logic                                in_clk,
  input  logic                                in_rst,
  input  logic [NUM_REQ-1:0]                  in_req,
  input  logic [NUM_REQ-1:0]                  in_we,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   in_addr,
  input  logic [NUM_REQ-1:0][WORD_BITS-1:0]   in_wdata,
  output logic [NUM_REQ-1:0]                  out_ack,
  output logic [NUM_REQ-1:0]                  out_grant,
  output logic [WORD_BITS-1:0]                out_rdata,
  output logic                                out_busy,
  output logic                                out_ram_read_ena,
  output logic                                out_ram_write_ena,
  output logic [ADDR_BITS-1:0]                out_ram_addr,
  output logic [WORD_BITS-1:0]                out_ram_data,
  input  logic [WORD_BITS-1:0]                in_ram_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_idx;
  logic               r_we;

  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_next_ptr;
  int                 w_k;

  // Pick the first active request starting at the round-robin pointer.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_k        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && in_req[w_k]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(w_k);
      end else begin
        w_found = w_found;
      end
    end
    w_next_ptr = PTR_W'((int'(w_sel) + 1) % NUM_REQ);
  end

  // Transaction FSM; every output is a register so the RAM port is glitch-free.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state           <= ST_IDLE;
      r_ptr             <= '0;
      r_idx             <= '0;
      r_we              <= 1'b0;
      out_ack           <= '0;
      out_grant         <= '0;
      out_rdata         <= '0;
      out_busy          <= 1'b0;
      out_ram_read_ena  <= 1'b0;
      out_ram_write_ena <= 1'b0;
      out_ram_addr      <= '0;
      out_ram_data      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          out_ack <= '0;
          if (w_found) begin
            r_idx             <= w_sel;
            r_we              <= in_we[w_sel];
            r_ptr             <= w_next_ptr;
            out_grant         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            out_busy          <= 1'b1;
            out_ram_write_ena <= in_we[w_sel];
            out_ram_read_ena  <= ~in_we[w_sel];
            // The RAM port registers double as the latched address and data.
            out_ram_addr      <= in_addr[w_sel];
            out_ram_data      <= in_we[w_sel] ? in_wdata[w_sel] : {WORD_BITS{1'b0}};
            r_state           <= ST_ISSUE;
          end else begin
            out_grant <= '0;
            out_busy  <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          out_ram_read_ena  <= 1'b0;
          out_ram_write_ena <= 1'b0;
          out_ram_addr      <= '0;
          out_ram_data      <= '0;
          r_state           <= ST_WAIT;
        end
        ST_WAIT: begin
          out_rdata <= r_we ? {WORD_BITS{1'b0}} : in_ram_data;
          out_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
          r_state   <= ST_ACK;
        end
        ST_ACK: begin
          out_ack   <= '0;
          out_grant <= '0;
          out_rdata <= '0;
          out_busy  <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state           <= ST_IDLE;
          out_ack           <= '0;
          out_grant         <= '0;
          out_busy          <= 1'b0;
          out_ram_read_ena  <= 1'b0;
          out_ram_write_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule
